// File: rtl/calc_pkg.sv
// calc1 port driver shared types: command/response codes,
// driver FSM states and default widths.
package calc_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CMD_W_DEF  = 4;
  localparam int RESP_W_DEF = 2;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RESP_NONE    = 2'd0;
  localparam logic [1:0] RESP_OK      = 2'd1;
  localparam logic [1:0] RESP_ERR     = 2'd2;
  localparam logic [1:0] RESP_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_OP1,
    ST_SEND_OP2,
    ST_WAIT_RESP,
    ST_DELIVER
  } state_e;

endpackage

// File: rtl/calc_req_fifo.sv
// Request buffer: synchronous FIFO of packed {cmd, op1, op2}.
// Ports: push/wdata in, pop/rdata out (show-ahead), full, count.
module calc_req_fifo #(
  parameter int WIDTH = 68,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && (count_q != CW'(DEPTH));
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (do_push && !do_pop)
      count_d = count_q + CW'(1);
    else if (!do_push && do_pop)
      count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

endmodule

// File: rtl/calc_port_driver.sv
// Request engine for one calc1 port: buffers {cmd,op1,op2} from a
// valid/ready stream, drives the two-cycle calc request, waits for
// the response (or times out) and returns it on a valid/ready stream.
// Ports: s_* request in, req_* calc request out, calc_* calc response
// in, m_* response out, busy (FSM active), spurious_resp (stray resp).
module calc_port_driver
  import calc_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_W_DEF,
  parameter int CMD_WIDTH      = CMD_W_DEF,
  parameter int RESP_WIDTH     = RESP_W_DEF,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [CMD_WIDTH-1:0]  s_cmd,
  input  logic [DATA_WIDTH-1:0] s_op1,
  input  logic [DATA_WIDTH-1:0] s_op2,
  output logic [CMD_WIDTH-1:0]  req_cmd_out,
  output logic [DATA_WIDTH-1:0] req_data_out,
  input  logic [RESP_WIDTH-1:0] calc_resp_in,
  input  logic [DATA_WIDTH-1:0] calc_data_in,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [RESP_WIDTH-1:0] m_resp,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy,
  output logic                  spurious_resp
);

  localparam int FW = CMD_WIDTH + 2 * DATA_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [FW-1:0]         fifo_rdata;
  logic                  fifo_full;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_pop;
  logic [CMD_WIDTH-1:0]  head_cmd;
  logic [DATA_WIDTH-1:0] head_op1, head_op2;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_op2_q, hold_op2_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [CMD_WIDTH-1:0]  req_cmd_q, req_cmd_d;
  logic [DATA_WIDTH-1:0] req_data_q, req_data_d;
  logic                  m_valid_q, m_valid_d;
  logic [RESP_WIDTH-1:0] m_resp_q, m_resp_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  busy_q, busy_d;
  logic                  spur_q, spur_d;
  logic                  cool_q, cool_d;

  calc_req_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s_valid),
    .wdata ({s_cmd, s_op1, s_op2}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign {head_cmd, head_op1, head_op2} = fifo_rdata;
  assign s_ready = !fifo_full;

  always_comb begin
    state_d    = state_q;
    hold_op2_d = hold_op2_q;
    timer_d    = timer_q;
    req_cmd_d  = '0;
    req_data_d = '0;
    m_valid_d  = m_valid_q;
    m_resp_d   = m_resp_q;
    m_data_d   = m_data_q;
    cool_d     = 1'b0;
    fifo_pop   = 1'b0;
    spur_d     = (calc_resp_in != '0) &&
                 (state_q != ST_WAIT_RESP);
    unique case (state_q)
      // Outputs are registered, so op1 is loaded
      // on the same edge that enters SEND_OP1.
      // cool_q holds off one cycle after a
      // handshake before the next pop.
      ST_IDLE: begin
        if (fifo_count != '0 && !cool_q) begin
          fifo_pop   = 1'b1;
          req_cmd_d  = head_cmd;
          req_data_d = head_op1;
          hold_op2_d = head_op2;
          state_d    = ST_SEND_OP1;
        end
      end
      ST_SEND_OP1: begin
        req_data_d = hold_op2_q;
        state_d    = ST_SEND_OP2;
      end
      ST_SEND_OP2: begin
        timer_d = '0;
        state_d = ST_WAIT_RESP;
      end
      ST_WAIT_RESP: begin
        if (calc_resp_in != '0) begin
          m_valid_d = 1'b1;
          m_resp_d  = calc_resp_in;
          m_data_d  = calc_data_in;
          state_d   = ST_DELIVER;
        end else if (timer_q ==
                     TW'(TIMEOUT_CYCLES - 1)) begin
          m_valid_d = 1'b1;
          m_resp_d  = RESP_WIDTH'(RESP_TIMEOUT);
          m_data_d  = '0;
          state_d   = ST_DELIVER;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_DELIVER: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          m_resp_d  = '0;
          m_data_d  = '0;
          cool_d    = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      hold_op2_q <= '0;
      timer_q    <= '0;
      req_cmd_q  <= '0;
      req_data_q <= '0;
      m_valid_q  <= 1'b0;
      m_resp_q   <= '0;
      m_data_q   <= '0;
      busy_q     <= 1'b0;
      spur_q     <= 1'b0;
      cool_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_op2_q <= hold_op2_d;
      timer_q    <= timer_d;
      req_cmd_q  <= req_cmd_d;
      req_data_q <= req_data_d;
      m_valid_q  <= m_valid_d;
      m_resp_q   <= m_resp_d;
      m_data_q   <= m_data_d;
      busy_q     <= busy_d;
      spur_q     <= spur_d;
      cool_q     <= cool_d;
    end
  end

  assign req_cmd_out   = req_cmd_q;
  assign req_data_out  = req_data_q;
  assign m_valid       = m_valid_q;
  assign m_resp        = m_resp_q;
  assign m_data        = m_data_q;
  assign busy          = busy_q;
  assign spurious_resp = spur_q;

endmodule
